// File: rtl/reg_in_capture_if.sv
// reg_in_capture_if: valid/ready peripheral register bus bundle.
// Latency: none, wires only.
// Backpressure: none; ready is a one-cycle completion pulse from the slave.
// Signals: valid/wstrb/addr/wdata from master, ready/rdata from slave.
interface reg_in_capture_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output valid, wstrb, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  valid, wstrb, addr, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/reg_in_capture.sv
// reg_in_capture: synchronised WIDTH-bit input register with sticky edge flags and irq.
// Latency: access completes 1 clk after valid; input -> DATA SYNC_STAGES clks, flag +1, irq +1.
// Backpressure: none; ready is a one-cycle pulse, valid must drop or change after it.
// Ports: clk, resetn (async active-low), bus (slave side of reg_in_capture_if),
//        in (asynchronous external inputs, WIDTH 1..32), irq (registered level interrupt).
// Map (addr[4:2]): 0 DATA ro, 1 RISE w1c, 2 FALL w1c, 3 IE rw, 4..7 reserved (read 0).
module reg_in_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  reg_in_capture_if.slave       bus,
  input  logic [WIDTH-1:0]      in,
  output logic                  irq
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_RISE = 3'd1;
  localparam logic [2:0] REG_FALL = 3'd2;
  localparam logic [2:0] REG_IE   = 3'd3;

  // State
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] ie_q, ie_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;

  // Combinational helpers
  logic [WIDTH-1:0] sync_val;
  logic             armed;
  logic [WIDTH-1:0] rise_evt;
  logic [WIDTH-1:0] fall_evt;
  logic             access;
  logic             is_write;
  logic [31:0]      lane_mask;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wbits;
  logic [WIDTH-1:0] clr_rise;
  logic [WIDTH-1:0] clr_fall;
  logic [31:0]      rd_val;
  logic             unused_bits;

  assign sync_val = sync_q[SYNC_STAGES-1];

  // Edge flags stay disarmed until the chain and prev hold real post-reset
  // samples, so a level present at reset release is never taken as an edge.
  assign armed = (arm_cnt_q == ARM_W'(ARM_MAX));

  always_comb begin
    sync_d[0] = in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d    = sync_val;
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
    rise_evt  = armed ? (sync_val & ~prev_q) : '0;
    fall_evt  = armed ? (~sync_val & prev_q) : '0;
  end

  // Bus decode. Only lanes with a strobe set are touched; bits above WIDTH
  // simply have no storage behind them.
  assign access    = bus.valid & ~ready_q;
  assign is_write  = |bus.wstrb;
  assign lane_mask = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}},
                      {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
  assign wmask     = lane_mask[WIDTH-1:0];
  assign wbits     = bus.wdata[WIDTH-1:0] & wmask;

  assign unused_bits = ^{bus.addr[31:5], bus.addr[1:0], bus.wdata, lane_mask};

  always_comb begin
    rd_val = '0;
    case (bus.addr[4:2])
      REG_DATA: rd_val = 32'(sync_val);
      REG_RISE: rd_val = 32'(rise_q);
      REG_FALL: rd_val = 32'(fall_q);
      REG_IE:   rd_val = 32'(ie_q);
      default:  rd_val = '0;
    endcase
  end

  always_comb begin
    ready_d  = access;
    rdata_d  = rdata_q;
    ie_d     = ie_q;
    clr_rise = '0;
    clr_fall = '0;
    if (access) begin
      if (is_write) begin
        rdata_d = '0;
        case (bus.addr[4:2])
          REG_RISE: clr_rise = wbits;
          REG_FALL: clr_fall = wbits;
          REG_IE:   ie_d     = (ie_q & ~wmask) | wbits;
          default:  ;
        endcase
      end else begin
        rdata_d = rd_val;
      end
    end
    // A fresh edge in the same cycle as a clear keeps the flag set.
    rise_d = (rise_q & ~clr_rise) | rise_evt;
    fall_d = (fall_q & ~clr_fall) | fall_evt;
    irq_d  = |((rise_q | fall_q) & ie_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q    <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      ie_q      <= '0;
      arm_cnt_q <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q    <= prev_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      ie_q      <= ie_d;
      arm_cnt_q <= arm_cnt_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign irq       = irq_q;

endmodule
